// File: rtl/bpu_gshare.sv
// Gshare branch predictor with a tagged BTB: registered 1-cycle lookup and a
// commit-order update port. Lookups always see pre-update table/history contents.
module bpu_gshare #(
  parameter int XLEN    = 32,
  parameter int INDEX_W = 8,
  parameter int GHR_W   = 8,
  parameter int CTR_W   = 2,
  parameter int TAG_W   = 20,
  parameter bit HASH_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_lookup_valid,
  input  logic [XLEN-1:0]  i_lookup_pc,
  output logic             o_pred_valid,
  output logic             o_pred_hit,
  output logic             o_pred_taken,
  output logic [XLEN-1:0]  o_pred_target,
  output logic [GHR_W-1:0] o_pred_ghr,
  input  logic             i_upd_valid,
  input  logic [XLEN-1:0]  i_upd_pc,
  input  logic             i_upd_taken,
  input  logic [XLEN-1:0]  i_upd_target,
  input  logic [GHR_W-1:0] i_upd_ghr
);

  localparam int DEPTH = 1 << INDEX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((64'd1 << (CTR_W - 1)) - 64'd1);
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};

  generate
    if (GHR_W < 1 || GHR_W > INDEX_W || CTR_W < 1 || INDEX_W < 1 || TAG_W < 1 ||
        INDEX_W + TAG_W + 2 > XLEN) begin : g_bad_params
      $error("bpu_gshare: illegal parameter combination");
    end
  endgenerate

  function automatic logic [INDEX_W-1:0] calc_cidx(input logic [INDEX_W-1:0] pidx,
                                                   input logic [GHR_W-1:0]   ghr);
    logic [INDEX_W-1:0] idx;
    if (HASH_EN) begin
      idx = pidx ^ INDEX_W'(ghr);
    end else begin
      idx = pidx;
    end
    return idx;
  endfunction

  function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] cur,
                                                input logic             taken);
    logic [CTR_W-1:0] nxt;
    nxt = cur;
    if (taken) begin
      if (cur != CTR_MAX) nxt = cur + CTR_W'(1'b1);
      else                nxt = cur;
    end else begin
      if (cur != {CTR_W{1'b0}}) nxt = cur - CTR_W'(1'b1);
      else                      nxt = cur;
    end
    return nxt;
  endfunction

  logic             btb_valid_r  [DEPTH];
  logic [TAG_W-1:0] btb_tag_r    [DEPTH];
  logic [XLEN-1:0]  btb_target_r [DEPTH];
  logic [CTR_W-1:0] ctr_r        [DEPTH];
  logic [GHR_W-1:0] ghr_r;

  logic [INDEX_W-1:0] lk_pidx_s, lk_cidx_s, up_pidx_s, up_cidx_s;
  logic [TAG_W-1:0]   lk_tag_s, up_tag_s;
  logic               lk_hit_s;
  logic [GHR_W-1:0]   ghr_next_s;
  logic               unused_pc_bits_s;

  assign lk_pidx_s = i_lookup_pc[INDEX_W+1:2];
  assign lk_tag_s  = i_lookup_pc[INDEX_W+TAG_W+1:INDEX_W+2];
  assign lk_cidx_s = calc_cidx(lk_pidx_s, ghr_r);
  assign up_pidx_s = i_upd_pc[INDEX_W+1:2];
  assign up_tag_s  = i_upd_pc[INDEX_W+TAG_W+1:INDEX_W+2];
  // Training uses the history the prediction was made with, not the live one.
  assign up_cidx_s = calc_cidx(up_pidx_s, i_upd_ghr);
  assign lk_hit_s  = btb_valid_r[lk_pidx_s] && (btb_tag_r[lk_pidx_s] == lk_tag_s);
  assign unused_pc_bits_s = ^{i_lookup_pc, i_upd_pc};

  generate
    if (GHR_W == 1) begin : g_ghr_one
      assign ghr_next_s = i_upd_taken;
    end else begin : g_ghr_shift
      assign ghr_next_s = {ghr_r[GHR_W-2:0], i_upd_taken};
    end
  endgenerate

  // Prediction outputs, history, valid bits and counters (reset-cleared state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        btb_valid_r[i] <= 1'b0;
        ctr_r[i]       <= CTR_INIT;
      end
      ghr_r         <= '0;
      o_pred_valid  <= 1'b0;
      o_pred_hit    <= 1'b0;
      o_pred_taken  <= 1'b0;
      o_pred_target <= '0;
      o_pred_ghr    <= '0;
    end else begin
      o_pred_valid  <= i_lookup_valid;
      o_pred_hit    <= i_lookup_valid && lk_hit_s;
      o_pred_taken  <= i_lookup_valid && lk_hit_s && ctr_r[lk_cidx_s][CTR_W-1];
      o_pred_target <= (i_lookup_valid && lk_hit_s) ? btb_target_r[lk_pidx_s] : '0;
      o_pred_ghr    <= i_lookup_valid ? ghr_r : '0;
      if (i_upd_valid) begin
        ctr_r[up_cidx_s] <= sat_step(ctr_r[up_cidx_s], i_upd_taken);
        ghr_r            <= ghr_next_s;
        if (i_upd_taken) begin
          btb_valid_r[up_pidx_s] <= 1'b1;
        end
      end
    end
  end

  // BTB payload; only meaningful behind a set valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    if (i_upd_valid && i_upd_taken) begin
      btb_tag_r[up_pidx_s]    <= up_tag_s;
      btb_target_r[up_pidx_s] <= i_upd_target;
    end
  end

endmodule
